// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues loads/stores on a req/ready bus, formats load data,
// stalls upstream while an access is in flight, passes other ops straight through.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_result_in,
    input  logic [31:0] ex_store_data_in,
    input  logic [4:0]  ex_rd_addr_in,
    input  logic        ex_reg_write_en_in,
    input  logic [1:0]  ex_mem_to_reg_in,
    input  logic        ex_mem_read_in,
    input  logic        ex_mem_write_in,
    input  logic [2:0]  ex_funct3_in,
    output logic [31:0] mem_alu_result_out,
    output logic [31:0] mem_load_data_out,
    output logic [4:0]  mem_rd_addr_out,
    output logic        mem_reg_write_en_out,
    output logic [1:0]  mem_mem_to_reg_out,
    output logic        mem_stall_out,
    output logic        misalign_out,
    output logic        bus_err_out,
    mem_access_stage_if.master dmem
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        load_q, load_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               bus_err_q, bus_err_d;

    logic               access_c;
    logic               legal_c;
    logic               aligned_c;

    // Select byte/halfword by address offset, then sign- or zero-extend.
    function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = word;
        endcase
    endfunction

    // Classify the incoming instruction: access, funct3 legality, alignment.
    always_comb begin
        access_c = ex_mem_read_in | ex_mem_write_in;
        legal_c  = 1'b0;
        if (ex_mem_write_in) begin
            legal_c = (ex_funct3_in == 3'b000) || (ex_funct3_in == 3'b001) ||
                      (ex_funct3_in == 3'b010);
        end else begin
            legal_c = (ex_funct3_in == 3'b000) || (ex_funct3_in == 3'b001) ||
                      (ex_funct3_in == 3'b010) || (ex_funct3_in == 3'b100) ||
                      (ex_funct3_in == 3'b101);
        end
        case (ex_funct3_in[1:0])
            2'b01:   aligned_c = ~ex_alu_result_in[0];
            2'b10:   aligned_c = (ex_alu_result_in[1:0] == 2'b00);
            default: aligned_c = 1'b1;
        endcase
    end

    // Next-state, request registers and stage outputs.
    always_comb begin
        state_d              = state_q;
        req_d                = req_q;
        we_d                 = we_q;
        addr_d               = addr_q;
        wdata_d              = wdata_q;
        be_d                 = be_q;
        funct3_d             = funct3_q;
        off_d                = off_q;
        load_d               = load_q;
        cnt_d                = cnt_q;
        fault_d              = fault_q;
        bus_err_d            = 1'b0;
        mem_stall_out        = 1'b0;
        mem_reg_write_en_out = ex_reg_write_en_in;
        mem_load_data_out    = 32'd0;
        misalign_out         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    mem_reg_write_en_out = 1'b0;
                    if (!(legal_c && aligned_c)) begin
                        misalign_out = 1'b1;
                    end else begin
                        mem_stall_out = 1'b1;
                        req_d    = 1'b1;
                        we_d     = ex_mem_write_in;
                        addr_d   = {ex_alu_result_in[31:2], 2'b00};
                        funct3_d = ex_funct3_in;
                        off_d    = ex_alu_result_in[1:0];
                        cnt_d    = '0;
                        fault_d  = 1'b0;
                        if (ex_mem_write_in) begin
                            case (ex_funct3_in[1:0])
                                2'b00: begin
                                    wdata_d = {4{ex_store_data_in[7:0]}};
                                    be_d    = 4'b0001 << ex_alu_result_in[1:0];
                                end
                                2'b01: begin
                                    wdata_d = {2{ex_store_data_in[15:0]}};
                                    be_d    = 4'b0011 << ex_alu_result_in[1:0];
                                end
                                default: begin
                                    wdata_d = ex_store_data_in;
                                    be_d    = 4'b1111;
                                end
                            endcase
                        end else begin
                            wdata_d = 32'd0;
                            be_d    = 4'b1111;
                        end
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                mem_stall_out        = 1'b1;
                mem_reg_write_en_out = 1'b0;
                cnt_d                = cnt_q + CNT_W'(1);
                if (dmem.dmem_ready) begin
                    load_d  = fmt_load(dmem.dmem_rdata, funct3_q, off_q);
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
                    load_d    = 32'd0;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    fault_d   = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                mem_load_data_out    = load_q;
                mem_reg_write_en_out = ex_reg_write_en_in & ~fault_q;
                state_d              = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            funct3_q  <= 3'd0;
            off_q     <= 2'd0;
            load_q    <= 32'd0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            load_q    <= load_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem_alu_result_out = ex_alu_result_in;
    assign mem_rd_addr_out    = ex_rd_addr_in;
    assign mem_mem_to_reg_out = ex_mem_to_reg_in;
    assign bus_err_out        = bus_err_q;
    assign dmem.dmem_req      = req_q;
    assign dmem.dmem_we       = we_q;
    assign dmem.dmem_addr     = addr_q;
    assign dmem.dmem_wdata    = wdata_q;
    assign dmem.dmem_be       = be_q;

endmodule
